maj7_vote_collector: RTL and testbench
======================================

Name: maj7_vote_collector

Overview:
- Upstream feeder for the 7-input majority network.
- Accepts single-bit votes serially over a valid/ready handshake and assembles them into an NVOTES-bit vector.
- Presents the assembled vector, its popcount and a reference majority bit on a registered valid/ready output.
- The vector drives x0..x6 of the majority block; out_maj is the golden value the bench compares against y0.

Parameters:
- NVOTES, 7, votes per frame; odd, 3..15.
- CW, derived localparam = ceil(log2(NVOTES+1)), width of the vote counter and out_count (3 for NVOTES=7).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  vote present on in_bit.
- in_ready  output  1  collector can accept a vote this cycle.
- in_bit  input  1  vote value.
- flush  input  1  synchronous abort of the current frame.
- out_valid  output  1  completed frame available.
- out_ready  input  1  consumer takes the frame this cycle.
- out_vec  output  NVOTES  assembled votes; bit i = i-th accepted vote of the frame (bit0 maps to x0).
- out_count  output  CW  number of 1 votes in out_vec.
- out_maj  output  1  1 iff out_count >= (NVOTES+1)/2.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=COLLECT, idx=0, cnt=0, vec=0.
  - out_valid=0, out_vec=0, out_count=0, out_maj=0.
  - in_ready=1 from the first clock edge after release.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready is a pure decode of state.
- Accept: in_valid & in_ready at a rising edge. On accept in COLLECT:
  - vec[idx] <= in_bit.
  - cnt <= cnt + in_bit.
  - idx <= idx + 1.
- Frame completion: accept with idx == NVOTES-1.
  - Next cycle: state=HOLD, out_valid=1.
  - out_vec = full vector including the last vote; out_count = final count; out_maj computed from the final count.
  - Latency: last vote accepted at edge k, so out_valid is high after edge k.
- In COLLECT, idle cycles (in_valid=0) change nothing; idx and cnt hold.
- In HOLD:
  - out_vec, out_count and out_maj are held stable while out_ready=0.
  - in_valid is ignored because in_ready=0.
- Output handshake: out_valid & out_ready at an edge.
  - state <= COLLECT; idx, cnt and vec cleared.
  - out_valid drops next cycle.
  - out_vec, out_count and out_maj keep their last values (don't-care while out_valid=0) until the next frame completes.
- Throughput: at most one frame per NVOTES+1 cycles; no same-cycle accept of a new vote during HOLD.
- flush (synchronous, highest priority over accept and output handshake):
  - Next state COLLECT; idx=0, cnt=0, vec=0, out_valid=0.
  - Any frame pending in HOLD is discarded.
  - A vote presented in the same cycle as flush is dropped.
- Counter widths: cnt never exceeds NVOTES, so no overflow; idx wraps only through completion or flush.
- Invariant checked by assertion: out_valid implies out_count == popcount(out_vec) and out_maj == majority(out_vec).
- rst_n asserted mid-frame or in HOLD aborts immediately; there is no partial-frame recovery.

Test Plan:
- Reset, then votes 1,0,1,1,0,0,1 on consecutive cycles -> out_valid high after 7th accept edge; out_vec=7'b1001101, out_count=4, out_maj=1; in_ready=0 during HOLD.
- Votes 0,1,0,0,1,1,0 with in_valid gaps of 2 cycles between votes -> idx/cnt hold during gaps; out_vec=7'b0110010, out_count=3, out_maj=0.
- Complete frame, hold out_ready=0 for 5 cycles while driving in_valid=1 -> outputs stable, no vote accepted; out_ready=1 -> out_valid low next cycle, in_ready high.
- Accept 4 votes (1,1,1,1), pulse flush, then send 0,0,0,0,0,0,1 -> out_vec=7'b1000000, out_count=1, out_maj=0; pre-flush votes absent.
- Flush asserted in HOLD together with out_ready=1 -> out_valid=0 next cycle, state COLLECT, no frame delivered twice.
- Drop rst_n asynchronously (between edges) after 3 votes -> outputs zero immediately; after release a full 7-vote frame of all 1s gives out_vec=7'h7F, out_count=7, out_maj=1.

Source files
------------

// File: rtl/maj7_vote_collector.sv
`default_nettype none
// ============================================================================
// maj7_vote_collector: serial vote collector; assembles NVOTES single-bit votes
// into a frame and presents vector, popcount and majority on valid/ready.
// Revision: 1.0
// ============================================================================
module maj7_vote_collector #(
  parameter int NVOTES = 7,
  localparam int CW = $clog2(NVOTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NVOTES-1:0] out_vec,
  output logic [CW-1:0]     out_count,
  output logic              out_maj
);

  localparam int MAJ = (NVOTES + 1) / 2;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NVOTES-1:0] vec_q, vec_d;
  logic [NVOTES-1:0] out_vec_q, out_vec_d;
  logic [CW-1:0]     out_count_q, out_count_d;
  logic              out_maj_q, out_maj_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COLLECT;
      idx_q       <= '0;
      cnt_q       <= '0;
      vec_q       <= '0;
      out_vec_q   <= '0;
      out_count_q <= '0;
      out_maj_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      out_vec_q   <= out_vec_d;
      out_count_q <= out_count_d;
      out_maj_q   <= out_maj_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    out_vec_d   = out_vec_q;
    out_count_d = out_count_q;
    out_maj_d   = out_maj_q;

    // flush outranks both handshakes; result registers keep their stale values
    if (flush) begin
      state_d = S_COLLECT;
      idx_d   = '0;
      cnt_d   = '0;
      vec_d   = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            vec_d[idx_q] = in_bit;
            cnt_d        = cnt_q + CW'(in_bit);
            idx_d        = idx_q + CW'(1);
            if (idx_q == CW'(NVOTES - 1)) begin
              state_d     = S_HOLD;
              out_vec_d   = vec_d;
              out_count_d = cnt_d;
              out_maj_d   = (cnt_d >= CW'(MAJ));
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_COLLECT;
            idx_d   = '0;
            cnt_d   = '0;
            vec_d   = '0;
          end
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_HOLD);
  assign out_vec   = out_vec_q;
  assign out_count = out_count_q;
  assign out_maj   = out_maj_q;

endmodule
`default_nettype wire

// File: tb/tb_maj7_vote_collector.sv
`default_nettype none
// Directed bench for maj7_vote_collector (NVOTES=7).
module tb_maj7_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_vec;
  logic [2:0] out_count;
  logic       out_maj;

  int checks = 0;
  int errors = 0;

  maj7_vote_collector #(.NVOTES(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_maj   (out_maj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] v);
    for (int i = 0; i < 7; i++) vote(v[i]);
  endtask

  task automatic chk_frame(input string tag, input logic [6:0] v, input logic [2:0] c, input logic m);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_vec"},   32'(out_vec),   32'(v));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_maj"},   32'(out_maj),   32'(m));
    chk({tag, "_rdy"},   32'(in_ready),  32'd0);
  endtask

  task automatic deliver(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"},   32'(in_ready),  32'd1);
  endtask

  // Frame consistency whenever a frame is offered
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      assert (out_count === 3'($countones(out_vec)) && out_maj === (out_count >= 3'd4))
      else begin
        errors++;
        $error("FAIL invariant observed=%0h/%0h/%0h expected count=%0h", out_vec, out_count, out_maj,
               $countones(out_vec));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_vec",   32'(out_vec),   32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_maj",   32'(out_maj),   32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // back-to-back votes 1,0,1,1,0,0,1
    vote(1); vote(0); vote(1); vote(1); vote(0); vote(0);
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    vote(1);
    chk_frame("t1", 7'b1001101, 3'd4, 1'b1);
    deliver("t1");

    // votes 0,1,0,0,1,1,0 with two idle cycles between
    vote(0); tick(); tick();
    vote(1); tick(); tick();
    vote(0); tick(); tick();
    vote(0); tick(); tick();
    vote(1); tick(); tick();
    vote(1); tick(); tick();
    chk("t2_gap_valid", 32'(out_valid), 32'd0);
    vote(0);
    chk_frame("t2", 7'b0110010, 3'd3, 1'b0);
    deliver("t2");

    // HOLD with stalled consumer and votes pushed at it
    send_frame(7'b0000011);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_vec",   32'(out_vec),   32'h03);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_rdy",   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; in_bit = 1'b0;
    chk("t3_count", 32'(out_count), 32'd2);
    deliver("t3");

    // flush mid-frame; the vote offered with flush is dropped
    vote(1); vote(1); vote(1); vote(1);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk("t4_flush_rdy", 32'(in_ready), 32'd1);
    vote(0); vote(0); vote(0); vote(0); vote(0); vote(0);
    chk("t4_not_yet", 32'(out_valid), 32'd0);
    vote(1);
    chk_frame("t4", 7'b1000000, 3'd1, 1'b0);
    deliver("t4");

    // flush together with out_ready in HOLD
    send_frame(7'b1010101);
    chk_frame("t5", 7'b1010101, 3'd4, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_flush_rdy",   32'(in_ready),  32'd1);
    tick();
    chk("t5_no_repeat", 32'(out_valid), 32'd0);
    send_frame(7'b0011100);
    chk_frame("t5b", 7'b0011100, 3'd3, 1'b0);
    deliver("t5b");

    // asynchronous reset mid-frame
    vote(1); vote(1); vote(1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_vec",   32'(out_vec),   32'd0);
    chk("t6_rst_count", 32'(out_count), 32'd0);
    chk("t6_rst_maj",   32'(out_maj),   32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    vote(1); vote(1); vote(1); vote(1); vote(1); vote(1);
    chk("t6_not_yet", 32'(out_valid), 32'd0);
    vote(1);
    chk_frame("t6", 7'h7F, 3'd7, 1'b1);
    deliver("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
